// File: rtl/tsip_pkg.sv
// Shared TSIP framing constants and the timing-packet parser state encoding.
package tsip_pkg;

    localparam logic [7:0] TSIP_DLE         = 8'h10;
    localparam logic [7:0] TSIP_ETX         = 8'h03;
    localparam logic [7:0] TSIP_ID_TIMING   = 8'h8F;
    localparam logic [7:0] TSIP_SUB_PRIMARY = 8'hAB;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GOT_DLE,
        ST_SKIP,
        ST_SKIP_DLE,
        ST_GOT_ID,
        ST_PAYLOAD,
        ST_PAY_DLE,
        ST_END_DLE,
        ST_END_ETX
    } tsip_state_e;

    // States that belong to a recognised timing packet; only these may report errors.
    function automatic logic is_timing_state(tsip_state_e s);
        return s inside {ST_GOT_ID, ST_PAYLOAD, ST_PAY_DLE, ST_END_DLE, ST_END_ETX};
    endfunction

endpackage

// File: rtl/tsip_timing_parser.sv
// Decodes TSIP 0x8F-0xAB primary timing packets from the UART byte stream and
// publishes the UTC fields as one coherent snapshot with a single-cycle strobe.
module tsip_timing_parser
    import tsip_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 20000,
    parameter int PAYLOAD_LEN  = 16,
    parameter int SEC_IDX      = 9
) (
    input  logic       i_clk_10,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_dv,
    output logic [7:0] o_seconds,
    output logic [7:0] o_minutes,
    output logic [7:0] o_hour,
    output logic [7:0] o_day,
    output logic [7:0] o_month,
    output logic [7:0] o_year_h,
    output logic [7:0] o_year_l,
    output logic       o_time_valid,
    output logic       o_pkt_err
);

    localparam int         CNT_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_LEN - 1);
    localparam int         NFIELDS  = 7;

    tsip_state_e      state, state_nxt;
    logic [4:0]       idx;
    logic [CNT_W-1:0] tmo_cnt;
    logic [NFIELDS-1:0][7:0] shadow;
    logic store_en, idx_clr, commit_nxt, err_nxt, timeout;

    always_comb begin
        state_nxt  = state;
        store_en   = 1'b0;
        idx_clr    = 1'b0;
        commit_nxt = 1'b0;
        err_nxt    = 1'b0;
        timeout    = 1'b0;
        if (i_rx_dv) begin
            case (state)
                ST_IDLE:
                    if (i_rx_data == TSIP_DLE) state_nxt = ST_GOT_DLE;
                ST_GOT_DLE, ST_SKIP_DLE: begin
                    // A non-stuffed, non-ETX byte after DLE in a foreign packet starts a new packet ID.
                    if (i_rx_data == TSIP_ID_TIMING)  state_nxt = ST_GOT_ID;
                    else if (i_rx_data == TSIP_DLE)   state_nxt = (state == ST_GOT_DLE) ? ST_GOT_DLE : ST_SKIP;
                    else if (i_rx_data == TSIP_ETX)   state_nxt = ST_IDLE;
                    else                              state_nxt = ST_SKIP;
                end
                ST_GOT_ID: begin
                    if (i_rx_data == TSIP_SUB_PRIMARY) begin
                        state_nxt = ST_PAYLOAD;
                        idx_clr   = 1'b1;
                    end else if (i_rx_data == TSIP_DLE) state_nxt = ST_SKIP_DLE;
                    else                                state_nxt = ST_SKIP;
                end
                ST_PAYLOAD:
                    if (i_rx_data == TSIP_DLE) state_nxt = ST_PAY_DLE;
                    else                       store_en  = 1'b1;
                ST_PAY_DLE:
                    if (i_rx_data == TSIP_DLE) store_en = 1'b1;
                    else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                ST_END_DLE:
                    if (i_rx_data == TSIP_DLE) state_nxt = ST_END_ETX;
                    else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                ST_END_ETX: begin
                    state_nxt = ST_IDLE;
                    if (i_rx_data == TSIP_ETX) commit_nxt = 1'b1;
                    else                       err_nxt    = 1'b1;
                end
                ST_SKIP:
                    if (i_rx_data == TSIP_DLE) state_nxt = ST_SKIP_DLE;
                default: state_nxt = ST_IDLE;
            endcase
            if (store_en) state_nxt = (idx >= LAST_IDX) ? ST_END_DLE : ST_PAYLOAD;
        end else if (state != ST_IDLE && tmo_cnt == TMO_LAST) begin
            timeout   = 1'b1;
            state_nxt = ST_IDLE;
            err_nxt   = is_timing_state(state);
        end
    end

    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            tmo_cnt <= '0;
            shadow  <= '0;
        end else begin
            state <= state_nxt;
            if (i_rx_dv || state == ST_IDLE || timeout) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + 1'b1;
            if (idx_clr)                        idx <= '0;
            else if (store_en && idx != 5'h1F)  idx <= idx + 5'd1;
            for (int k = 0; k < NFIELDS; k++)
                if (store_en && idx == 5'(SEC_IDX + k)) shadow[NFIELDS-1-k] <= i_rx_data;
        end
    end

    // Fields only ever change together on a committed packet, so consumers see a coherent time.
    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {o_seconds, o_minutes, o_hour, o_day, o_month, o_year_h, o_year_l} <= '0;
            o_time_valid <= 1'b0;
            o_pkt_err    <= 1'b0;
        end else begin
            o_time_valid <= commit_nxt;
            o_pkt_err    <= err_nxt;
            if (commit_nxt)
                {o_seconds, o_minutes, o_hour, o_day, o_month, o_year_h, o_year_l} <= shadow;
        end
    end

endmodule
